// File: rtl/rf_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// rf_access_ctrl_if
// Request / response bundle between a client and rf_access_ctrl.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both high. The sender holds valid and its payload
// stable until that edge. The receiver may raise ready independently of
// valid.
//
// Signals:
//   req_valid  / req_ready   request channel handshake
//   req_op                   00 write, 01 read pair, 10 clear-all, 11 reserved
//   req_addr_a               write address / read port A address
//   req_addr_b               read port B address
//   req_wdata                write data
//   rsp_valid  / rsp_ready   read response channel handshake
//   rsp_data_a / rsp_data_b  read results
//
// Modports:
//   master  client side (drives requests, accepts responses)
//   slave   controller side
// ---------------------------------------------------------------------------
interface rf_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [4:0]  req_addr_a;
    logic [4:0]  req_addr_b;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data_a;
    logic [31:0] rsp_data_b;

    modport master (
        output req_valid, req_op, req_addr_a, req_addr_b, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data_a, rsp_data_b
    );

    modport slave (
        input  req_valid, req_op, req_addr_a, req_addr_b, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data_a, rsp_data_b
    );
endinterface

// File: rtl/rf_access_ctrl.sv
// ---------------------------------------------------------------------------
// rf_access_ctrl
// Sequences write, read-pair and clear-all requests onto a register file
// with one write port and two read ports with one-cycle registered read
// latency.
//
// Parameters:
//   CLEAR_VALUE  word written to all 32 registers by a clear-all request
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   bus            request/response channels (rf_access_ctrl_if.slave)
//   rf_w_*         register file write port
//   rf_ra_addr/rf_rb_addr, rf_ra_data/rf_rb_data  register file read ports
//   busy           high whenever the FSM is not IDLE
//   dbg_state      current FSM state encoding, for observation only
//
// Optional feature (macro RF_ZERO_REG_EN):
//   When defined, register 0 is hard-wired to zero: writes to address 0 keep
//   rf_w_ena low and reads of address 0 return 32'h0.
// ---------------------------------------------------------------------------
module rf_access_ctrl #(
    parameter logic [31:0] CLEAR_VALUE = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    rf_access_ctrl_if.slave      bus,
    output logic [31:0]          rf_w_data,
    output logic [4:0]           rf_w_addr,
    output logic                 rf_w_ena,
    output logic [4:0]           rf_ra_addr,
    output logic [4:0]           rf_rb_addr,
    input  logic [31:0]          rf_ra_data,
    input  logic [31:0]          rf_rb_data,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

`ifdef RF_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        RESP    = 3'd4,
        CLR     = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  cnt;
    logic [4:0]  wr_addr_q;
    logic [31:0] wr_data_q;
    logic        accept;
    logic [4:0]  w_addr;

    assign accept = (state == IDLE) && bus.req_valid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; reserved op is accepted in IDLE and simply dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    case (bus.req_op)
                        OP_WRITE: state_next = WR;
                        OP_READ:  state_next = RD_ADDR;
                        OP_CLEAR: state_next = CLR;
                        default:  state_next = IDLE;
                    endcase
                end
            end
            WR:      state_next = IDLE;
            RD_ADDR: state_next = RD_DATA;
            RD_DATA: state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            // Leaving on address 31 means the 5-bit wrap never restarts a pass.
            CLR:     if (cnt == 5'd31) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.rsp_valid = (state == RESP);
        busy          = (state != IDLE);
        dbg_state     = state;
        w_addr        = (state == CLR) ? cnt : wr_addr_q;
        rf_w_addr     = w_addr;
        rf_w_data     = (state == CLR) ? CLEAR_VALUE : wr_data_q;
        rf_w_ena      = ((state == WR) || (state == CLR)) &&
                        !(ZERO_REG && (w_addr == 5'd0));
    end

    // Datapath registers. Read addresses are only loaded on acceptance of a
    // read, so they hold their last value everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= 5'd0;
            wr_addr_q      <= 5'd0;
            wr_data_q      <= 32'h0;
            rf_ra_addr     <= 5'd0;
            rf_rb_addr     <= 5'd0;
            bus.rsp_data_a <= 32'h0;
            bus.rsp_data_b <= 32'h0;
        end else begin
            if (accept && (bus.req_op == OP_WRITE)) begin
                wr_addr_q <= bus.req_addr_a;
                wr_data_q <= bus.req_wdata;
            end
            if (accept && (bus.req_op == OP_READ)) begin
                rf_ra_addr <= bus.req_addr_a;
                rf_rb_addr <= bus.req_addr_b;
            end
            if (accept && (bus.req_op == OP_CLEAR)) begin
                cnt <= 5'd0;
            end else if (state == CLR) begin
                cnt <= cnt + 5'd1;
            end
            // RF data is valid in RD_DATA because of its registered read.
            if (state == RD_DATA) begin
                bus.rsp_data_a <= (ZERO_REG && (rf_ra_addr == 5'd0)) ? 32'h0 : rf_ra_data;
                bus.rsp_data_b <= (ZERO_REG && (rf_rb_addr == 5'd0)) ? 32'h0 : rf_rb_data;
            end
        end
    end

endmodule

// File: tb/tb_rf_access_ctrl.sv
module tb_rf_access_ctrl;

`ifdef RF_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    localparam logic [31:0] CLR_VAL = 32'hA5A5_A5A5;

    logic        clk;
    logic        rst;
    logic [31:0] rf_w_data;
    logic [4:0]  rf_w_addr;
    logic        rf_w_ena;
    logic [4:0]  rf_ra_addr;
    logic [4:0]  rf_rb_addr;
    logic [31:0] rf_ra_data;
    logic [31:0] rf_rb_data;
    logic        busy;
    logic [2:0]  dbg_state;

    rf_access_ctrl_if bus ();

    rf_access_ctrl #(.CLEAR_VALUE(CLR_VAL)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .rf_w_data  (rf_w_data),
        .rf_w_addr  (rf_w_addr),
        .rf_w_ena   (rf_w_ena),
        .rf_ra_addr (rf_ra_addr),
        .rf_rb_addr (rf_rb_addr),
        .rf_ra_data (rf_ra_data),
        .rf_rb_data (rf_rb_data),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // Register file with one-cycle registered read
    logic [31:0] rf_mem [32];
    always @(posedge clk) begin
        if (rf_w_ena) rf_mem[rf_w_addr] <= rf_w_data;
        rf_ra_data <= rf_mem[rf_ra_addr];
        rf_rb_data <= rf_mem[rf_rb_addr];
    end

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard state
    logic [36:0] wr_exp_q[$];   // {addr, data}
    logic [63:0] rsp_exp_q[$];  // {data_a, data_b}
    logic [31:0] model_mem [32];
    int checks;
    int fails;

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        return (ZERO && a == 5'd0) ? 32'h0 : model_mem[a];
    endfunction

    // Monitor: checks every RF write and every response handshake
    task automatic monitor();
        logic [36:0] we;
        logic [63:0] re;
        forever begin
            @(negedge clk);
            if (rf_w_ena) begin
                checks++;
                if (wr_exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: got addr %0d data %h, required no write", rf_w_addr, rf_w_data);
                end else begin
                    we = wr_exp_q.pop_front();
                    if ({rf_w_addr, rf_w_data} !== we) begin
                        fails++;
                        $display("FAIL rf_write: got addr %0d data %h, required addr %0d data %h",
                                 rf_w_addr, rf_w_data, we[36:32], we[31:0]);
                    end
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                checks++;
                if (rsp_exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_rsp: got %h %h, required no response", bus.rsp_data_a, bus.rsp_data_b);
                end else begin
                    re = rsp_exp_q.pop_front();
                    if ({bus.rsp_data_a, bus.rsp_data_b} !== re) begin
                        fails++;
                        $display("FAIL rsp_data: got %h %h, required %h %h",
                                 bus.rsp_data_a, bus.rsp_data_b, re[63:32], re[31:0]);
                    end
                end
            end
        end
    endtask

    // Driver: waits for req_ready, presents a request, returns 1 time unit
    // after the accepting edge.
    task automatic do_req(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                          input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.req_ready) begin
            fails++;
            $display("FAIL req_ready_timeout: got req_ready %b, required 1", bus.req_ready);
        end
        bus.req_op     = op;
        bus.req_addr_a = a;
        bus.req_addr_b = b;
        bus.req_wdata  = d;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
    endtask

    task automatic push_write(input logic [4:0] a, input logic [31:0] d);
        if (!(ZERO && a == 5'd0)) begin
            wr_exp_q.push_back({a, d});
            model_mem[a] = d;
        end
    endtask

    task automatic push_read(input logic [4:0] a, input logic [4:0] b);
        rsp_exp_q.push_back({exp_read(a), exp_read(b)});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_timeout: got busy %b, required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || busy !== 1'b0 || dbg_state !== 3'd0) begin
            fails++;
            $display("FAIL reset_ctrl: got ready %b busy %b state %0d, required 1 0 0",
                     bus.req_ready, busy, dbg_state);
        end
        checks++;
        if (rf_w_ena !== 1'b0 || rf_w_addr !== 5'd0 || rf_w_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_wport: got ena %b addr %0d data %h, required 0 0 0",
                     rf_w_ena, rf_w_addr, rf_w_data);
        end
        checks++;
        if (rf_ra_addr !== 5'd0 || rf_rb_addr !== 5'd0 || bus.rsp_valid !== 1'b0 ||
            bus.rsp_data_a !== 32'h0 || bus.rsp_data_b !== 32'h0) begin
            fails++;
            $display("FAIL reset_rport: got ra %0d rb %0d vld %b a %h b %h, required all 0",
                     rf_ra_addr, rf_rb_addr, bus.rsp_valid, bus.rsp_data_a, bus.rsp_data_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_write();
        push_write(5'd5, 32'hDEAD_BEEF);
        do_req(2'b00, 5'd5, 5'd0, 32'hDEAD_BEEF);
        checks++;
        if (rf_w_ena !== 1'b1 || busy !== 1'b1 || bus.req_ready !== 1'b0) begin
            fails++;
            $display("FAIL write_cycle: got ena %b busy %b ready %b, required 1 1 0",
                     rf_w_ena, busy, bus.req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rf_w_ena !== 1'b0 || bus.req_ready !== 1'b1) begin
            fails++;
            $display("FAIL write_done: got ena %b ready %b, required 0 1", rf_w_ena, bus.req_ready);
        end
        push_write(5'd7, 32'h1234_5678);
        do_req(2'b00, 5'd7, 5'd0, 32'h1234_5678);
        wait_idle();
    endtask

    task automatic test_read();
        bus.rsp_ready = 1'b1;
        push_read(5'd5, 5'd7);
        do_req(2'b01, 5'd5, 5'd7, 32'h0);
        checks++;
        if (bus.rsp_valid !== 1'b0 || rf_ra_addr !== 5'd5 || rf_rb_addr !== 5'd7) begin
            fails++;
            $display("FAIL read_addr: got vld %b ra %0d rb %0d, required 0 5 7",
                     bus.rsp_valid, rf_ra_addr, rf_rb_addr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL read_early: got rsp_valid %b, required 0", bus.rsp_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data_a !== 32'hDEAD_BEEF || bus.rsp_data_b !== 32'h1234_5678) begin
            fails++;
            $display("FAIL read_rsp: got vld %b a %h b %h, required 1 deadbeef 12345678",
                     bus.rsp_valid, bus.rsp_data_a, bus.rsp_data_b);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            fails++;
            $display("FAIL read_done: got vld %b ready %b, required 0 1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [31:0] ea;
        logic [31:0] eb;
        ea = exp_read(5'd7);
        eb = exp_read(5'd5);
        bus.rsp_ready = 1'b0;
        push_read(5'd7, 5'd5);
        do_req(2'b01, 5'd7, 5'd5, 32'h0);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data_a !== ea || bus.rsp_data_b !== eb) begin
                fails++;
                $display("FAIL hold_%0d: got vld %b a %h b %h, required 1 %h %h",
                         i, bus.rsp_valid, bus.rsp_data_a, bus.rsp_data_b, ea, eb);
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || dbg_state !== 3'd0) begin
            fails++;
            $display("FAIL release: got vld %b state %0d, required 0 0", bus.rsp_valid, dbg_state);
        end
    endtask

    task automatic test_reserved();
        do_req(2'b11, 5'd3, 5'd4, 32'hFFFF_0000);
        checks++;
        if (busy !== 1'b0 || bus.req_ready !== 1'b1 || rf_w_ena !== 1'b0) begin
            fails++;
            $display("FAIL reserved: got busy %b ready %b ena %b, required 0 1 0",
                     busy, bus.req_ready, rf_w_ena);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_clear();
        int n;
        for (int i = 0; i < 32; i++) push_write(5'(i), CLR_VAL);
        do_req(2'b10, 5'd0, 5'd0, 32'h0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        checks++;
        if (n != 32) begin
            fails++;
            $display("FAIL clear_busy: got %0d busy cycles, required 32", n);
        end
        checks++;
        if (wr_exp_q.size() != 0) begin
            fails++;
            $display("FAIL clear_count: got %0d writes missing, required 0", wr_exp_q.size());
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        push_read(5'd0, 5'd31);
        do_req(2'b01, 5'd0, 5'd31, 32'h0);
        wait_idle();
    endtask

    task automatic test_reset_mid_clear();
        push_write(5'd10, 32'h1111_2222);
        do_req(2'b00, 5'd10, 5'd0, 32'h1111_2222);
        wait_idle();
        for (int i = 0; i < 10; i++) push_write(5'(i), CLR_VAL);
        do_req(2'b10, 5'd0, 5'd0, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (rf_w_ena !== 1'b0 || busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_clear: got ena %b busy %b vld %b, required 0 0 0",
                     rf_w_ena, busy, bus.rsp_valid);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (wr_exp_q.size() != 0) begin
            fails++;
            $display("FAIL abort_count: got %0d writes missing, required 0", wr_exp_q.size());
        end
        push_read(5'd9, 5'd10);
        do_req(2'b01, 5'd9, 5'd10, 32'h0);
        wait_idle();
    endtask

    task automatic test_zero_reg();
        push_write(5'd0, 32'hFFFF_FFFF);
        do_req(2'b00, 5'd0, 5'd0, 32'hFFFF_FFFF);
        checks++;
        if (rf_w_ena !== !ZERO) begin
            fails++;
            $display("FAIL zero_write_ena: got %b, required %b", rf_w_ena, !ZERO);
        end
        wait_idle();
        push_read(5'd0, 5'd10);
        do_req(2'b01, 5'd0, 5'd10, 32'h0);
        wait_idle();
        checks++;
        if (bus.rsp_data_a !== (ZERO ? 32'h0 : 32'hFFFF_FFFF)) begin
            fails++;
            $display("FAIL zero_read: got %h, required %h", bus.rsp_data_a,
                     (ZERO ? 32'h0 : 32'hFFFF_FFFF));
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  a;
        logic [4:0]  b;
        logic [31:0] d;
        int n;
        for (int t = 0; t < 24; t++) begin
            a = 5'($urandom_range(0, 31));
            b = 5'($urandom_range(0, 31));
            d = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                push_write(a, d);
                do_req(2'b00, a, b, d);
            end else begin
                bus.rsp_ready = 1'($urandom_range(0, 1));
                push_read(a, b);
                do_req(2'b01, a, b, d);
                n = 0;
                while (!bus.rsp_valid && n < 20) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                bus.rsp_ready = 1'b1;
            end
            wait_idle();
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'b00;
        bus.req_addr_a = 5'd0;
        bus.req_addr_b = 5'd0;
        bus.req_wdata  = 32'h0;
        bus.rsp_ready  = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_reserved();
        test_clear();
        test_reset_mid_clear();
        test_zero_reg();
        test_back_to_back();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (wr_exp_q.size() != 0 || rsp_exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d writes %0d responses outstanding, required 0 0",
                     wr_exp_q.size(), rsp_exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/rf_access_ctrl.md
RF_ACCESS_CTRL -- requirements
Module: rf_access_ctrl

Interface
REQ-001 SHALL have parameter CLEAR_VALUE, default 32'h0000_0000, the word written to every register by a clear operation.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, request present.
REQ-005 SHALL have port req_ready, output, 1, request accepted when high together with req_valid at a rising edge.
REQ-006 SHALL have port req_op, input, 2, operation: 00 write, 01 read pair, 10 clear-all, 11 reserved.
REQ-007 SHALL have ports req_addr_a and req_addr_b, input, 5 each, write/read-A address and read-B address.
REQ-008 SHALL have port req_wdata, input, 32, write data.
REQ-009 SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1), the read-response handshake.
REQ-010 SHALL have ports rsp_data_a and rsp_data_b, output, 32 each, read results.
REQ-011 SHALL have register-file-side ports rf_w_data (out, 32), rf_w_addr (out, 5), rf_w_ena (out, 1), rf_ra_addr (out, 5), rf_rb_addr (out, 5), rf_ra_data (in, 32), rf_rb_data (in, 32), matching a register file with one-cycle registered read latency.
REQ-012 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, WR, RD_ADDR, RD_DATA, RESP, CLR; req_ready SHALL be high only in IDLE.
REQ-014 Write accepted at edge N: SHALL enter WR, drive rf_w_ena=1, rf_w_addr=req_addr_a, rf_w_data=req_wdata for exactly the cycle after edge N, then return to IDLE at edge N+1; no response is generated.
REQ-015 Read accepted at edge N: SHALL enter RD_ADDR with rf_ra_addr/rf_rb_addr registered from req_addr_a/req_addr_b; edge N+1 enters RD_DATA; edge N+2 captures rf_ra_data/rf_rb_data into rsp_data_a/rsp_data_b, raises rsp_valid and enters RESP.
REQ-016 In RESP, rsp_valid and rsp_data_* SHALL hold stable until rsp_valid&&rsp_ready at an edge, then return to IDLE with rsp_valid low.
REQ-017 Clear accepted at edge N: SHALL enter CLR with a 5-bit counter at 0 and drive rf_w_ena=1, rf_w_addr=counter, rf_w_data=CLEAR_VALUE for 32 consecutive cycles (addresses 0..31), then return to IDLE after the cycle for address 31.
REQ-018 Reserved op 11 SHALL be accepted and discarded; state stays IDLE, no RF port activity.
REQ-019 rf_w_ena SHALL be low in every state except WR and CLR.
REQ-020 rf_ra_addr/rf_rb_addr SHALL hold their last value outside RD_ADDR.
REQ-021 Counter wrap at 31 SHALL NOT start a second clear pass.

Reset
REQ-022 rst high SHALL immediately force state IDLE and clear counter, rsp_valid, rsp_data_a, rsp_data_b, rf_w_ena, rf_w_addr, rf_w_data, rf_ra_addr, rf_rb_addr, and busy to 0; req_ready SHALL be 1 after reset.
REQ-023 Reset asserted mid-clear or mid-read SHALL abort the operation with no further RF writes and no response.

Configuration
REQ-024 Macro RF_ZERO_REG_EN: when defined, writes to address 0 (WR or CLR) SHALL keep rf_w_ena low, and a read of address 0 on either port SHALL return 32'h0 regardless of rf_*_data; when undefined, address 0 SHALL behave as any other register.

Verification
REQ-025 Write op, addr_a=5, wdata=32'hDEAD_BEEF -> rf_w_ena high for one cycle with rf_w_addr=5, rf_w_data=32'hDEAD_BEEF; req_ready back high next cycle.
REQ-026 Read op addr_a=5, addr_b=7, RF model returning 32'hDEAD_BEEF and 32'h1234_5678 -> rsp_valid rises two edges after acceptance with those values.
REQ-027 Read with rsp_ready low for 4 cycles -> rsp_valid and data held stable 4 cycles; IDLE one edge after rsp_ready rises.
REQ-028 Clear with CLEAR_VALUE=32'hA5A5_A5A5 -> exactly 32 rf_w_ena cycles, addresses 0..31 in order, busy high for 32 cycles.
REQ-029 rst asserted after 10 clear cycles -> rf_w_ena low immediately, busy low, no writes to addresses 10..31.
REQ-030 With RF_ZERO_REG_EN: write addr 0 -> no rf_w_ena pulse; read addr_a=0 with RF returning 32'hFFFF_FFFF -> rsp_data_a=0; without the macro -> pulse occurs and rsp_data_a=32'hFFFF_FFFF.
